rv_x_regs_wb_sched: RTL and testbench

- Schedules the single write port of the 32x32 integer register file between two writeback sources: the fixed-latency ALU and the variable-latency LSU.
- Holds a pending-write scoreboard for long (LSU) ops and gates instruction issue on RAW/WAW hazards against it.
- Prevents LSU starvation by holding issue until the queued LSU write drains.
- Sits between the issue stage, the execute units and the register file. Its registered rd / rd_store_value drive the register file write port directly.

---
 rtl/rv_x_regs_wb_sched.sv | 143 ++++++++++++++
 tb/tb_rv_x_regs_wb_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_x_regs_wb_sched.sv
// rv_x_regs_wb_sched: register-file write-port scheduler, ALU vs LSU.
// Tracks pending LSU writes in a scoreboard and gates issue on hazards.
//
// Ports:
//   clock, reset          clock, async active-low reset
//   issue_valid/long/rd/rs1/rs2, issue_ready   issue-stage handshake
//   alu_wb_valid/rd/value                       ALU writeback (always wins)
//   lsu_wb_valid/rd/value, lsu_wb_ready         LSU writeback handshake
//   rd, rd_store_value    registered regfile write port (rd=0: no write)
//   busy                  pending LSU write scoreboard, bit 0 tied 0
module rv_x_regs_wb_sched #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  output logic        issue_ready,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_value,
  input  logic        lsu_wb_valid,
  output logic        lsu_wb_ready,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_value,
  output logic [4:0]  rd,
  output logic [31:0] rd_store_value,
  output logic [31:0] busy
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] value;
  } wb_ent_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_ent_t     slot_q;
  logic        slot_valid;
  logic [3:0]  starve_q;
  logic        hold;
  logic        wb_from_lsu;

  logic        lsu_fire;
  logic        slot_drain;
  logic        issue_set;
  logic [4:0]  sel_rd;
  logic [31:0] sel_value;
  logic        sel_lsu;
  logic [31:0] busy_set;
  logic [31:0] busy_clr;
  logic [31:0] busy_d;

  assign hold         = (starve_q == LIMIT);
  assign lsu_wb_ready = !slot_valid || !alu_wb_valid;
  assign lsu_fire     = lsu_wb_valid && lsu_wb_ready;
  assign slot_drain   = slot_valid && !alu_wb_valid;

  assign issue_ready = !hold
                    && !busy[issue_rs1]
                    && !busy[issue_rs2]
                    && !busy[issue_rd];

  assign issue_set = issue_valid && issue_ready
                  && issue_long && (issue_rd != 5'd0);

  // ALU and a draining slot are mutually exclusive.
  always_comb begin
    sel_rd    = 5'd0;
    sel_value = rd_store_value;
    sel_lsu   = 1'b0;
    unique case (1'b1)
      alu_wb_valid: begin
        sel_rd    = alu_wb_rd;
        sel_value = alu_wb_value;
      end
      slot_drain: begin
        sel_rd    = slot_q.rd;
        sel_value = slot_q.value;
        sel_lsu   = 1'b1;
      end
      default: ;
    endcase
  end

  // Clear lands on the same edge the regfile commits the LSU value.
  always_comb begin
    busy_clr = '0;
    busy_set = '0;
    if (wb_from_lsu && (rd != 5'd0))
      busy_clr = 32'd1 << rd;
    if (issue_set)
      busy_set = 32'd1 << issue_rd;
    busy_d = ((busy & ~busy_clr) | busy_set) & ~32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd             <= 5'd0;
      rd_store_value <= 32'd0;
      wb_from_lsu    <= 1'b0;
    end else begin
      rd             <= sel_rd;
      rd_store_value <= sel_value;
      wb_from_lsu    <= sel_lsu;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      busy <= '0;
    else
      busy <= busy_d;
  end

  // A handshake is only possible when the slot is empty or draining,
  // so a fill simply overwrites whatever was there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid <= 1'b0;
      slot_q     <= '0;
    end else if (lsu_fire) begin
      slot_valid <= 1'b1;
      slot_q     <= '{rd: lsu_wb_rd, value: lsu_wb_value};
    end else if (slot_drain) begin
      slot_valid <= 1'b0;
    end
  end

  // Counts cycles the queued LSU write loses to the ALU.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      starve_q <= 4'd0;
    else if (!slot_valid || !alu_wb_valid)
      starve_q <= 4'd0;
    else if (!hold)
      starve_q <= starve_q + 4'd1;
  end

endmodule

// File: tb/tb_rv_x_regs_wb_sched.sv
// tb_rv_x_regs_wb_sched: directed and random checks of the wb scheduler
// against a queue-based reference model.
module tb_rv_x_regs_wb_sched;

  localparam int LIM = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] v;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_ready;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_value;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_value;
  logic [4:0]  rd;
  logic [31:0] rd_store_value;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;

  bit          m_busy[32];
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  bit          m_from;
  int          m_cnt;
  ent_t        m_slot[$];

  always #5 clock = ~clock;

  rv_x_regs_wb_sched #(.STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_ready(issue_ready),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
    .alu_wb_value(alu_wb_value),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_value(lsu_wb_value),
    .rd(rd), .rd_store_value(rd_store_value), .busy(busy)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_busyv();
    logic [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = m_busy[i];
    return b;
  endfunction

  function automatic bit m_ir();
    return (m_cnt != LIM) && !m_busy[issue_rs1]
        && !m_busy[issue_rs2] && !m_busy[issue_rd];
  endfunction

  function automatic bit m_lr();
    return (m_slot.size() == 0) || !alu_wb_valid;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_rd = '0; m_val = '0; m_from = 0; m_cnt = 0;
    m_slot.delete();
  endtask

  task automatic idle();
    issue_valid = 0; issue_long = 0;
    issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_value = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_value = 0;
  endtask

  // Entered at posedge+1 with inputs set; leaves at next posedge+1.
  task automatic cycle();
    bit   ir, lr, had;
    ent_t e;
    ir = m_ir();
    lr = m_lr();
    @(negedge clock);
    chk("issue_ready", 32'(issue_ready), 32'(ir));
    chk("lsu_wb_ready", 32'(lsu_wb_ready), 32'(lr));
    had = m_slot.size() != 0;
    if (m_from && m_rd != 0) m_busy[m_rd] = 0;
    if (issue_valid && ir && issue_long && issue_rd != 0)
      m_busy[issue_rd] = 1;
    if (alu_wb_valid) begin
      m_rd = alu_wb_rd; m_val = alu_wb_value; m_from = 0;
    end else if (had) begin
      e = m_slot.pop_front();
      m_rd = e.rd; m_val = e.v; m_from = 1;
    end else begin
      m_rd = 0; m_from = 0;
    end
    if (had && alu_wb_valid) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
    else m_cnt = 0;
    if (lsu_wb_valid && lr) begin
      m_slot.delete();
      m_slot.push_back('{rd: lsu_wb_rd, v: lsu_wb_value});
    end
    @(posedge clock);
    #1;
    chk("rd", 32'(rd), 32'(m_rd));
    chk("rd_store_value", rd_store_value, m_val);
    chk("busy", busy, m_busyv());
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_busy", busy, 32'd0);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("idle_ir", 32'(issue_ready), 32'd1);
      chk("idle_lr", 32'(lsu_wb_ready), 32'd1);
      cycle();
      chk("idle_rd", 32'(rd), 32'd0);
    end

    // long op, RAW hold, LSU completion
    issue_valid = 1; issue_long = 1; issue_rd = 5;
    issue_rs1 = 1; issue_rs2 = 2;
    cycle();
    issue_long = 0; issue_rd = 6; issue_rs1 = 5;
    #1 chk("raw_hold", 32'(issue_ready), 32'd0);
    cycle();
    idle();
    cycle();
    lsu_wb_valid = 1; lsu_wb_rd = 5; lsu_wb_value = 32'hDEADBEEF;
    cycle();
    idle();
    cycle();
    chk("lsu_rd5", 32'(rd), 32'd5);
    chk("lsu_val", rd_store_value, 32'hDEADBEEF);
    chk("busy5_pend", 32'(busy[5]), 32'd1);
    cycle();
    chk("busy5_clr", 32'(busy[5]), 32'd0);
    issue_valid = 1; issue_rd = 6; issue_rs1 = 5;
    #1 chk("raw_free", 32'(issue_ready), 32'd1);
    cycle();

    // ALU and LSU in the same cycle
    idle();
    alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_value = 1;
    lsu_wb_valid = 1; lsu_wb_rd = 7; lsu_wb_value = 2;
    #1 chk("both_lr", 32'(lsu_wb_ready), 32'd1);
    cycle();
    chk("both_n1", 32'(rd), 32'd3);
    idle();
    cycle();
    chk("both_n2", 32'(rd), 32'd7);
    chk("both_v2", rd_store_value, 32'd2);

    // starvation
    alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_value = 32'h11;
    lsu_wb_valid = 1; lsu_wb_rd = 8; lsu_wb_value = 32'h88;
    issue_valid = 1; issue_rd = 10; issue_rs1 = 11; issue_rs2 = 12;
    cycle();
    lsu_wb_valid = 0;
    for (int i = 0; i < 6; i++) begin
      alu_wb_value = 32'(i);
      #1 chk("starve_lr", 32'(lsu_wb_ready), 32'd0);
      chk("starve_ir", 32'(issue_ready), (i >= LIM) ? 32'd0 : 32'd1);
      cycle();
    end
    alu_wb_valid = 0;
    #1 chk("hold_drain", 32'(issue_ready), 32'd0);
    cycle();
    chk("starve_rd8", 32'(rd), 32'd8);
    chk("hold_clear", 32'(issue_ready), 32'd1);
    cycle();

    // LSU write to x0
    idle();
    lsu_wb_valid = 1; lsu_wb_rd = 0; lsu_wb_value = 32'hFFFFFFFF;
    #1 chk("x0_lr", 32'(lsu_wb_ready), 32'd1);
    cycle();
    idle();
    cycle();
    chk("x0_rd", 32'(rd), 32'd0);
    chk("x0_busy", busy, 32'd0);

    // async reset mid-operation
    issue_valid = 1; issue_long = 1; issue_rd = 9;
    issue_rs1 = 0; issue_rs2 = 0;
    cycle();
    idle();
    alu_wb_valid = 1; alu_wb_rd = 2; alu_wb_value = 32'h22;
    lsu_wb_valid = 1; lsu_wb_rd = 12; lsu_wb_value = 32'hC0C0;
    cycle();
    lsu_wb_valid = 0;
    cycle();
    chk("pre_busy9", 32'(busy[9]), 32'd1);
    chk("pre_slot", 32'(lsu_wb_ready), 32'd0);
    #2 reset = 0;
    #1;
    chk("arst_busy", busy, 32'd0);
    chk("arst_rd", 32'(rd), 32'd0);
    idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    model_reset();
    chk("post_lr", 32'(lsu_wb_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_nowr", 32'(rd), 32'd0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      issue_valid  = ($urandom_range(0, 1) == 1);
      issue_long   = ($urandom_range(0, 2) == 0);
      issue_rd     = 5'($urandom_range(0, 7));
      issue_rs1    = 5'($urandom_range(0, 7));
      issue_rs2    = 5'($urandom_range(0, 7));
      alu_wb_valid = ($urandom_range(0, 9) < 6);
      alu_wb_rd    = 5'($urandom_range(0, 31));
      alu_wb_value = $urandom;
      lsu_wb_valid = ($urandom_range(0, 9) < 4);
      lsu_wb_rd    = 5'($urandom_range(0, 7));
      lsu_wb_value = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
